// File: rtl/snail_pkg.sv
// snail_pkg: definitions shared by the time-multiplexed "01" snail detector.
//   snail_state_e : detector state encoding (2'b11 is unused and treated as IDLE)
//   snail_next()  : next state of one detector context for one accepted bit
//   SNAIL_NUM_CH / SNAIL_CNT_W : default channel count and counter width
package snail_pkg;

  localparam int unsigned SNAIL_NUM_CH = 4;
  localparam int unsigned SNAIL_CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ZERO  = 2'b01,
    ST_MATCH = 2'b10
  } snail_state_e;

  // Moore "01" detector step. IDLE and MATCH share transitions; the
  // unused code 2'b11 falls into the default arm so it behaves as IDLE.
  function automatic snail_state_e snail_next(input logic [1:0] state,
                                              input logic       b);
    snail_state_e nxt;
    case (state)
      2'b01:   nxt = b ? ST_MATCH : ST_ZERO;
      2'b10:   nxt = b ? ST_IDLE  : ST_ZERO;
      default: nxt = b ? ST_IDLE  : ST_ZERO;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/snail_rr_arb.sv
// snail_rr_arb: round-robin arbiter granting one requester per cycle.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   req_valid      : per-channel request
//   xfer           : a transfer happened on the current grant this cycle
//   grant          : one-hot grant (all-zero while reset or with no request)
//   grant_idx      : index of the granted channel (0 when nothing granted)
// The search starts at ptr; after a transfer ptr moves to granted+1 (mod NUM_CH).
module snail_rr_arb #(
  parameter  int unsigned NUM_CH = 4,
  localparam int unsigned CH_W   = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] req_valid,
  input  logic              xfer,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   grant_idx
);

  logic [CH_W-1:0] ptr_q;
  logic [CH_W-1:0] ptr_d;

  always_comb begin
    logic            found;
    int unsigned     idx;
    logic [CH_W-1:0] idx_c;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    idx_c     = '0;
    if (!reset) begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        idx   = (32'(ptr_q) + k) % NUM_CH;
        idx_c = idx[CH_W-1:0];
        if (!found && req_valid[idx_c]) begin
          found        = 1'b1;
          grant[idx_c] = 1'b1;
          grant_idx    = idx_c;
        end
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      ptr_d = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/snail_mux_ctrl.sv
// snail_mux_ctrl: one shared "01" smiling-snail Moore detector serving
// NUM_CH serial requesters. Each channel keeps its own saved detector
// context; the granted channel's context is advanced and written back.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   req_valid   : channel i presents a bit
//   req_bit     : bit value for channel i
//   req_ready   : one-hot grant; transfer when req_valid[i] & req_ready[i]
//   match_valid : one-cycle pulse, a channel's detector entered MATCH
//   match_ch    : channel that produced match_valid (holds otherwise)
//   cnt_sel     : counter read/clear select
//   cnt_clr     : clear counter cnt_sel at the next edge
//   cnt_out     : counter[cnt_sel], combinational read
module snail_mux_ctrl
  import snail_pkg::*;
#(
  parameter  int unsigned NUM_CH = SNAIL_NUM_CH,
  parameter  int unsigned CNT_W  = SNAIL_CNT_W,
  localparam int unsigned CH_W   = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] req_valid,
  input  logic [NUM_CH-1:0] req_bit,
  output logic [NUM_CH-1:0] req_ready,
  output logic              match_valid,
  output logic [CH_W-1:0]   match_ch,
  input  logic [CH_W-1:0]   cnt_sel,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  cnt_out
);

  logic [NUM_CH-1:0] grant;
  logic [CH_W-1:0]   grant_idx;
  logic              xfer;

  snail_state_e      ctx_q [NUM_CH];
  snail_state_e      ctx_d [NUM_CH];
  logic              match_valid_q, match_valid_d;
  logic [CH_W-1:0]   match_ch_q, match_ch_d;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic              hit;

  snail_rr_arb #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .xfer      (xfer),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Grant is already gated by reset inside the arbiter, so no transfer
  // can happen while reset is high.
  assign req_ready = grant;
  assign xfer      = |(req_valid & grant);

  // Shared detector: advance only the granted channel's context.
  always_comb begin
    snail_state_e nxt;
    ctx_d         = ctx_q;
    match_valid_d = 1'b0;
    match_ch_d    = match_ch_q;
    hit           = 1'b0;
    nxt           = ST_IDLE;
    if (xfer) begin
      nxt              = snail_next(ctx_q[grant_idx], req_bit[grant_idx]);
      ctx_d[grant_idx] = nxt;
      if (nxt == ST_MATCH) begin
        match_valid_d = 1'b1;
        match_ch_d    = grant_idx;
        hit           = 1'b1;
      end
    end
  end

  // Clear is applied before the increment so a coincident clear and
  // match on the same channel leaves the counter at 1.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (cnt_clr && (cnt_sel == CH_W'(i))) begin
        cnt_d[i] = '0;
      end
      if (hit && (grant_idx == CH_W'(i)) && (cnt_d[i] != '1)) begin
        cnt_d[i] = cnt_d[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        ctx_q[i] <= ST_IDLE;
        cnt_q[i] <= '0;
      end
      match_valid_q <= 1'b0;
      match_ch_q    <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        ctx_q[i] <= ctx_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      match_valid_q <= match_valid_d;
      match_ch_q    <= match_ch_d;
    end
  end

  assign match_valid = match_valid_q;
  assign match_ch    = match_ch_q;
  assign cnt_out     = (32'(cnt_sel) < NUM_CH) ? cnt_q[cnt_sel] : '0;

endmodule

// File: tb/tb_snail_mux_ctrl.sv
module tb_snail_mux_ctrl;

  localparam int NCH  = 4;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic           clk;
  logic           reset;
  logic [NCH-1:0] req_valid;
  logic [NCH-1:0] req_bit;
  logic [NCH-1:0] req_ready;
  logic           match_valid;
  logic [1:0]     match_ch;
  logic [1:0]     cnt_sel;
  logic           cnt_clr;
  logic [CW-1:0]  cnt_out;

  snail_mux_ctrl #(
    .NUM_CH (NCH),
    .CNT_W  (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_bit     (req_bit),
    .req_ready   (req_ready),
    .match_valid (match_valid),
    .match_ch    (match_ch),
    .cnt_sel     (cnt_sel),
    .cnt_clr     (cnt_clr),
    .cnt_out     (cnt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: previous accepted bit per channel (-1 = none since
  // reset), round-robin pointer, match counters, expected match queue.
  int m_prev [NCH];
  int m_cnt  [NCH];
  int m_ptr;
  int exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_prev[i] = -1;
      m_cnt[i]  = 0;
    end
    m_ptr = 0;
  endtask

  // One cycle: drive inputs after the falling edge, check the combinational
  // outputs, then advance the model for the coming rising edge.
  task automatic step(input logic rst, input logic [NCH-1:0] v, input logic [NCH-1:0] b,
                      input logic [1:0] sel, input logic clr, output int g);
    logic [NCH-1:0] exp_rdy;
    int idx;
    @(negedge clk);
    reset = rst; req_valid = v; req_bit = b; cnt_sel = sel; cnt_clr = clr;
    #1;
    g = -1;
    if (!rst) begin
      for (int k = 0; k < NCH; k++) begin
        idx = (m_ptr + k) % NCH;
        if (g < 0 && v[idx]) g = idx;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("cnt_out", 32'(cnt_out), 32'(m_cnt[sel]));
    if (rst) begin
      model_reset();
    end else begin
      if (clr) m_cnt[sel] = 0;
      if (g >= 0) begin
        if (m_prev[g] == 0 && b[g]) begin
          exp_q.push_back(g);
          if (m_cnt[g] < CMAX) m_cnt[g]++;
        end
        m_prev[g] = b[g] ? 1 : 0;
        m_ptr = (g + 1) % NCH;
      end
    end
  endtask

  // Monitor: every edge consumes at most one expected match.
  initial begin
    int e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("match_valid", 32'(match_valid), 32'd1);
        check("match_ch", 32'(match_ch), 32'(e));
      end else begin
        check("match_valid", 32'(match_valid), 32'd0);
      end
    end
  end

  initial begin
    int g;
    int bits1 [12];
    logic [NCH-1:0] pend, pb;
    logic rst;
    bits1 = '{0, 1, 1, 0, 0, 0, 1, 0, 1, 1, 1, 0};
    reset = 1'b1; req_valid = '0; req_bit = '0; cnt_sel = '0; cnt_clr = 1'b0;
    model_reset();

    // Reset state
    step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, g);
    step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, g);
    check("reset_cnt0", 32'(cnt_out), 32'd0);

    // Single channel 0 bit sequence: matches on bits 2, 7, 9
    foreach (bits1[i]) step(1'b0, 4'b0001, {3'b000, bits1[i][0]}, 2'd0, 1'b0, g);
    step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, g);
    check("seq_cnt0", 32'(cnt_out), 32'd3);

    // All channels valid, ch2 fed 0 then 1
    step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, g);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 4'b1111, (k < 4) ? 4'b1011 : 4'b1111, 2'd2, 1'b0, g);
      check("rr_order", 32'(req_ready), 32'(1 << (k % 4)));
    end
    step(1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0, g);
    check("rr_cnt2", 32'(cnt_out), 32'd1);

    // Context retained across a 20-cycle gap on ch1
    step(1'b0, 4'b0010, 4'b0000, 2'd1, 1'b0, g);
    for (int k = 0; k < 20; k++) step(1'b0, 4'b0000, 4'b0000, 2'd1, 1'b0, g);
    step(1'b0, 4'b0010, 4'b0010, 2'd1, 1'b0, g);
    step(1'b0, 4'b0000, 4'b0000, 2'd1, 1'b0, g);
    check("gap_cnt1", 32'(cnt_out), 32'd1);

    // Reset between ch0's 0 and 1
    step(1'b0, 4'b0001, 4'b0000, 2'd0, 1'b0, g);
    step(1'b1, 4'b0001, 4'b0001, 2'd0, 1'b0, g);
    check("ready_in_reset", 32'(req_ready), 32'd0);
    step(1'b0, 4'b0001, 4'b0001, 2'd0, 1'b0, g);
    for (int k = 0; k < NCH; k++) begin
      step(1'b0, 4'b0000, 4'b0000, 2'(k), 1'b0, g);
      check("post_reset_cnt", 32'(cnt_out), 32'd0);
    end

    // Saturation on ch3, then clear coincident with a match
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 4'b1000, 4'b0000, 2'd3, 1'b0, g);
      step(1'b0, 4'b1000, 4'b1000, 2'd3, 1'b0, g);
    end
    step(1'b0, 4'b0000, 4'b0000, 2'd3, 1'b0, g);
    check("sat_cnt3", 32'(cnt_out), 32'd3);
    step(1'b0, 4'b1000, 4'b0000, 2'd3, 1'b0, g);
    step(1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1, g);
    step(1'b0, 4'b0000, 4'b0000, 2'd3, 1'b0, g);
    check("clr_match_cnt3", 32'(cnt_out), 32'd1);

    // Pointer wrap: ptr=3 -> grant 3 then 0, ptr ends at 1
    step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, g);
    step(1'b0, 4'b0100, 4'b0100, 2'd0, 1'b0, g);
    step(1'b0, 4'b1001, 4'b1111, 2'd0, 1'b0, g);
    check("wrap_grant3", 32'(req_ready), 32'b1000);
    step(1'b0, 4'b1001, 4'b1111, 2'd0, 1'b0, g);
    check("wrap_grant0", 32'(req_ready), 32'b0001);
    step(1'b0, 4'b0011, 4'b1111, 2'd0, 1'b0, g);
    check("wrap_ptr1", 32'(req_ready), 32'b0010);

    // Randomized traffic with hold-until-transfer requesters
    step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, g);
    pend = '0; pb = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NCH; i++) begin
        if (pend[i]) begin
          if ($urandom_range(15) == 0) pend[i] = 1'b0;
        end else if ($urandom_range(1) == 1) begin
          pend[i] = 1'b1;
          pb[i]   = 1'($urandom_range(1));
        end
      end
      rst = ($urandom_range(99) == 0);
      step(rst, pend, pb, 2'($urandom_range(3)), ($urandom_range(7) == 0), g);
      if (g >= 0) pend[g] = 1'b0;
    end

    step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, g);
    step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, g);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
